conv_encoder_k7: RTL and testbench



---
 rtl/viterbi_pkg.sv | 19 +
 rtl/conv_encoder_k7_if.sv | 23 ++
 rtl/conv_enc_core.sv | 23 ++
 rtl/conv_encoder_k7.sv | 83 ++++++++
 tb/tb_conv_encoder_k7.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/viterbi_pkg.sv
// viterbi_pkg: code parameters, encoder FSM states and parity helper shared by the encoder and the Viterbi decoder
package viterbi_pkg;

    localparam int K = 7;
    localparam int NUM_STATES = 1 << (K - 1);
    localparam logic [K-1:0] G0 = 7'o171;
    localparam logic [K-1:0] G1 = 7'o133;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        TAIL
    } enc_state_t;

    function automatic logic parity(input logic [K-1:0] v);
        return ^v;
    endfunction

endpackage

// File: rtl/conv_encoder_k7_if.sv
// conv_encoder_k7_if: input bit stream and output symbol stream handshakes of the encoder
interface conv_encoder_k7_if;

    logic       in_valid;
    logic       in_ready;
    logic       in_bit;
    logic       in_last;
    logic       out_valid;
    logic       out_ready;
    logic [1:0] out_pair;
    logic       out_last;

    modport master (
        output in_valid, in_bit, in_last, out_ready,
        input  in_ready, out_valid, out_pair, out_last
    );

    modport slave (
        input  in_valid, in_bit, in_last, out_ready,
        output in_ready, out_valid, out_pair, out_last
    );

endinterface

// File: rtl/conv_enc_core.sv
// conv_enc_core: one trellis step, (u, sr) -> ({G0 parity, G1 parity}, next state)
module conv_enc_core
    import viterbi_pkg::*;
#(
    parameter logic [K-1:0] G0_POLY = G0,
    parameter logic [K-1:0] G1_POLY = G1
) (
    input  logic         u,
    input  logic [K-2:0] sr,
    output logic [1:0]   pair,
    output logic [K-2:0] next_sr
);

    logic [K-1:0] v;

    // The current bit sits in the MSB so it lines up with the polynomial MSB tap
    always_comb begin
        v       = {u, sr};
        pair    = {parity(G0_POLY & v), parity(G1_POLY & v)};
        next_sr = v[K-1:1];
    end

endmodule

// File: rtl/conv_encoder_k7.sv
// conv_encoder_k7: framed rate-1/2 K=7 convolutional encoder with optional zero tail
module conv_encoder_k7
    import viterbi_pkg::*;
#(
    parameter bit TAIL_EN = 1'b1
) (
    input logic            clk,
    input logic            rst_n,
    conv_encoder_k7_if.slave bus
);

    localparam int CW = $clog2(K);
    localparam logic [CW-1:0] TAIL_LEN = CW'(K - 1);

    enc_state_t    state;
    logic [K-2:0]  sr;
    logic [K-2:0]  next_sr;
    logic [CW-1:0] tail_cnt;
    logic          out_valid;
    logic          out_last;
    logic [1:0]    out_pair;
    logic [1:0]    pair;
    logic          load;
    logic          accept;
    logic          tail_step;
    logic          u;
    logic          end_no_tail;

    // Output register can take a new symbol when empty or being drained this cycle
    always_comb begin
        load        = !out_valid || bus.out_ready;
        accept      = bus.in_valid && (state != TAIL) && load;
        tail_step   = (state == TAIL) && load;
        u           = (state == TAIL) ? 1'b0 : bus.in_bit;
        end_no_tail = bus.in_last && !TAIL_EN;
    end

    assign bus.in_ready  = (state != TAIL) && load;
    assign bus.out_valid = out_valid;
    assign bus.out_pair  = out_pair;
    assign bus.out_last  = out_last;

    conv_enc_core u_core (
        .u       (u),
        .sr      (sr),
        .pair    (pair),
        .next_sr (next_sr)
    );

    // Frame FSM, trellis state and output symbol register; nothing moves while stalled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            sr        <= '0;
            tail_cnt  <= '0;
            out_valid <= 1'b0;
            out_pair  <= 2'b00;
            out_last  <= 1'b0;
        end else begin
            if (load)
                out_valid <= accept || tail_step;
            if (accept) begin
                out_pair <= pair;
                out_last <= end_no_tail;
                sr       <= end_no_tail ? '0 : next_sr;
                if (bus.in_last) begin
                    state    <= TAIL_EN ? TAIL : IDLE;
                    tail_cnt <= TAIL_EN ? TAIL_LEN : '0;
                end else begin
                    state <= DATA;
                end
            end else if (tail_step) begin
                out_pair <= pair;
                out_last <= (tail_cnt == CW'(1));
                sr       <= next_sr;
                tail_cnt <= tail_cnt - CW'(1);
                if (tail_cnt == CW'(1))
                    state <= IDLE;
            end
        end
    end

endmodule

// File: tb/tb_conv_encoder_k7.sv
// tb_conv_encoder_k7: vector table, hand sequences and random frames against a convolution model
module tb_conv_encoder_k7;

    typedef logic [2:0] sym_q_t[$];
    typedef bit bit_q_t[$];
    typedef struct {
        string        name;
        int           len;
        logic [15:0]  bits;
        int           nsym;
        logic [43:0]  pairs;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int n_checks = 0;
    int n_fail = 0;
    int rdy_pct = 100;
    sym_q_t got_a;
    sym_q_t got_b;

    conv_encoder_k7_if bus_a ();
    conv_encoder_k7_if bus_b ();

    conv_encoder_k7 #(.TAIL_EN(1'b1)) dut (.clk(clk), .rst_n(rst_n), .bus(bus_a));
    conv_encoder_k7 #(.TAIL_EN(1'b0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus_b));

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: each parity bit is the XOR of the tapped bits of the input history
    function automatic sym_q_t model(input bit_q_t bits, input bit tail);
        logic [6:0] g0 = 7'o171;
        logic [6:0] g1 = 7'o133;
        bit_q_t ext = bits;
        sym_q_t q;
        if (tail) repeat (6) ext.push_back(1'b0);
        for (int i = 0; i < ext.size(); i++) begin
            logic p1 = 1'b0;
            logic p0 = 1'b0;
            for (int j = 0; j < 7; j++) begin
                logic h = (i >= j) ? ext[i-j] : 1'b0;
                p1 ^= g0[6-j] & h;
                p0 ^= g1[6-j] & h;
            end
            q.push_back({p1, p0, i == ext.size() - 1});
        end
        return q;
    endfunction

    task automatic send_frame(input bit_q_t bits);
        int idx = 0;
        int cyc = 0;
        while (idx < bits.size() && cyc < 20000) begin
            @(posedge clk); #1;
            bus_a.in_valid = 1'b1;
            bus_a.in_bit   = bits[idx];
            bus_a.in_last  = (idx == bits.size() - 1);
            @(negedge clk);
            if (bus_a.in_ready) idx++;
            cyc++;
        end
        @(posedge clk); #1;
        bus_a.in_valid = 1'b0;
        bus_a.in_last  = 1'b0;
        if (idx < bits.size()) check("send_timeout", 32'(idx), 32'(bits.size()));
    endtask

    task automatic expect_syms(input string name, input sym_q_t exp, input bit side);
        int t = 0;
        sym_q_t g;
        while (((side ? got_b.size() : got_a.size()) < exp.size()) && t < 20000) begin
            @(negedge clk);
            t++;
        end
        repeat (3) @(negedge clk);
        if (side) begin
            g = got_b;
            got_b.delete();
        end else begin
            g = got_a;
            got_a.delete();
        end
        check({name, "_count"}, 32'(g.size()), 32'(exp.size()));
        foreach (exp[k])
            if (k < g.size()) check($sformatf("%s[%0d]", name, k), 32'(g[k]), 32'(exp[k]));
    endtask

    // Downstream back-pressure generator for the tailed encoder
    initial begin
        bus_a.out_ready = 1'b1;
        bus_b.out_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            bus_a.out_ready = (int'($urandom_range(99)) < rdy_pct);
        end
    end

    // Symbol collector and stall-stability monitor, sampled on the falling edge
    initial begin
        logic [2:0] prev = 3'b0;
        bit prev_stall = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n && prev_stall) begin
                check("stall_valid", 32'(bus_a.out_valid), 32'd1);
                check("stall_hold", 32'({bus_a.out_pair, bus_a.out_last}), 32'(prev));
            end
            if (rst_n && bus_a.out_valid && bus_a.out_ready)
                got_a.push_back({bus_a.out_pair, bus_a.out_last});
            if (rst_n && bus_b.out_valid && bus_b.out_ready)
                got_b.push_back({bus_b.out_pair, bus_b.out_last});
            prev_stall = rst_n && bus_a.out_valid && !bus_a.out_ready;
            prev = {bus_a.out_pair, bus_a.out_last};
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[3];
        bit_q_t b;
        sym_q_t e;
        sym_q_t e2;
        int idx;
        int cyc;
        vecs[0] = '{"zero16", 16, 16'h0000, 22, 44'h0};
        vecs[1] = '{"impulse", 1, 16'h0001, 7,
                    44'({2'b11, 2'b01, 2'b00, 2'b11, 2'b11, 2'b10, 2'b11})};
        vecs[2] = '{"f1011", 4, 16'b1101, 10,
                    44'({2'b11, 2'b10, 2'b01, 2'b00, 2'b01, 2'b01, 2'b10, 2'b00, 2'b10, 2'b11})};
        bus_a.in_valid = 1'b0; bus_a.in_bit = 1'b0; bus_a.in_last = 1'b0;
        bus_b.in_valid = 1'b0; bus_b.in_bit = 1'b0; bus_b.in_last = 1'b0;
        #12;
        check("rst_out_valid", 32'(bus_a.out_valid), 32'd0);
        check("rst_out_pair", 32'(bus_a.out_pair), 32'd0);
        check("rst_out_last", 32'(bus_a.out_last), 32'd0);
        check("rst_in_ready", 32'(bus_a.in_ready), 32'd1);
        check("rst_sr", 32'(dut.sr), 32'd0);
        check("rst0_out_valid", 32'(bus_b.out_valid), 32'd0);
        @(posedge clk); #2;
        rst_n = 1'b1;

        for (int v = 0; v < 3; v++) begin
            b.delete();
            e.delete();
            for (int i = 0; i < vecs[v].len; i++) b.push_back(vecs[v].bits[i]);
            for (int k = 0; k < vecs[v].nsym; k++)
                e.push_back({vecs[v].pairs[2*k +: 2], k == vecs[v].nsym - 1});
            send_frame(b);
            expect_syms(vecs[v].name, e, 1'b0);
            check({vecs[v].name, "_sr_end"}, 32'(dut.sr), 32'd0);
        end

        // Impulse, then a new one-bit frame held on the bus through the tail
        @(posedge clk); #1;
        bus_a.in_valid = 1'b1; bus_a.in_bit = 1'b1; bus_a.in_last = 1'b1;
        @(negedge clk);
        check("imp_accept", 32'(bus_a.in_ready), 32'd1);
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            bus_a.in_bit = 1'b0;
            @(negedge clk);
            check($sformatf("imp_tail_ready[%0d]", c), 32'(bus_a.in_ready), 32'd0);
        end
        @(posedge clk); #1;
        @(negedge clk);
        check("imp_ready_back", 32'(bus_a.in_ready), 32'd1);
        @(posedge clk); #1;
        bus_a.in_valid = 1'b0; bus_a.in_last = 1'b0;
        b = {1'b1};
        e = model(b, 1'b1);
        b = {1'b0};
        e2 = model(b, 1'b1);
        foreach (e2[k]) e.push_back(e2[k]);
        expect_syms("impulse_b2b", e, 1'b0);

        // Long random frame, unthrottled then with 50% back-pressure
        b.delete();
        for (int i = 0; i < 1000; i++) b.push_back(1'($urandom_range(1)));
        e = model(b, 1'b1);
        send_frame(b);
        expect_syms("rand_full", e, 1'b0);
        rdy_pct = 50;
        send_frame(b);
        expect_syms("rand_throttle", e, 1'b0);
        rdy_pct = 100;
        check("rand_sr_end", 32'(dut.sr), 32'd0);

        // Asynchronous reset in the middle of the tail
        b = {1'b1};
        send_frame(b);
        #3;
        rst_n = 1'b0;
        #1;
        check("arst_out_valid", 32'(bus_a.out_valid), 32'd0);
        check("arst_out_pair", 32'(bus_a.out_pair), 32'd0);
        check("arst_in_ready", 32'(bus_a.in_ready), 32'd1);
        check("arst_sr", 32'(dut.sr), 32'd0);
        @(posedge clk); #2;
        rst_n = 1'b1;
        got_a.delete();
        repeat (4) @(negedge clk);
        check("arst_no_symbols", 32'(got_a.size()), 32'd0);
        check("arst_idle_valid", 32'(bus_a.out_valid), 32'd0);
        b = {1'b1, 1'b1};
        e = model(b, 1'b1);
        send_frame(b);
        expect_syms("arst_next", e, 1'b0);

        // No-tail build: two back-to-back 3-bit frames
        b = {1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        idx = 0;
        cyc = 0;
        while (idx < 6 && cyc < 50) begin
            @(posedge clk); #1;
            bus_b.in_valid = 1'b1;
            bus_b.in_bit   = b[idx];
            bus_b.in_last  = (idx == 2 || idx == 5);
            @(negedge clk);
            if (bus_b.in_ready) idx++;
            cyc++;
        end
        @(posedge clk); #1;
        bus_b.in_valid = 1'b0; bus_b.in_last = 1'b0;
        check("notail_cycles", 32'(cyc), 32'd6);
        b = {1'b1, 1'b1, 1'b0};
        e = model(b, 1'b0);
        b = {1'b1, 1'b0, 1'b1};
        e2 = model(b, 1'b0);
        foreach (e2[k]) e.push_back(e2[k]);
        expect_syms("notail", e, 1'b1);
        check("notail_sr_end", 32'(dut0.sr), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
